// File: rtl/ddr3_ctrl_out_lane_pf.sv
// rtl/ddr3_ctrl_out_lane_pf.sv - DDR3 control output lanes with shared IOD delay tap sequencer
// Optional: DDR3_CTRL_TAP_READBACK_EN adds CUR_TAP_O (registered per-lane tap readback).
module ddr3_ctrl_out_lane_pf #(
    parameter int NUM_LANES  = 2,
    parameter int LANE_W     = 1,
    parameter int TAP_W      = 8,
    parameter int MAX_TAP    = 127,
    parameter int SETTLE_CYC = 3
) (
    input  logic                       FAB_CLK,
    input  logic                       ARST,
    input  logic [4*NUM_LANES-1:0]     CMD_DATA,
    input  logic [NUM_LANES-1:0]       CMD_OE_EN,
    output logic [4*NUM_LANES-1:0]     TX_DATA_O,
    output logic [4*NUM_LANES-1:0]     OE_DATA_O,
    input  logic                       TAP_REQ_VALID,
    output logic                       TAP_REQ_READY,
    input  logic [LANE_W-1:0]          TAP_REQ_LANE,
    input  logic [TAP_W-1:0]           TAP_REQ_VAL,
    input  logic                       TAP_REQ_LOAD,
    output logic                       TAP_DONE,
    output logic                       TAP_ERR,
    output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE_O,
    output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION_O,
    output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD_O,
    input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE_I
`ifdef DDR3_CTRL_TAP_READBACK_EN
    ,
    output logic [TAP_W*NUM_LANES-1:0] CUR_TAP_O
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD,
        S_STEP,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [TAP_W-1:0]   val_q, val_d;
    logic               load_q, load_d;
    logic               dir_q, dir_d;
    logic               err_q, err_d;
    logic               from_load_q, from_load_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [TAP_W-1:0]   cur_tap_q [NUM_LANES];
    logic [TAP_W-1:0]   cur_tap_d [NUM_LANES];
    logic [4*NUM_LANES-1:0] tx_q, oe_q;

    logic [TAP_W-1:0]   cur_sel;
    logic               oor_sel;
    logic [TAP_W-1:0]   new_tap;
    logic               req_bad;

    // Data path is independent of the sequencer
    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            tx_q <= '0;
            oe_q <= '0;
        end else begin
            tx_q <= CMD_DATA;
            for (int i = 0; i < NUM_LANES; i++) begin
                oe_q[4*i +: 4] <= {4{CMD_OE_EN[i]}};
            end
        end
    end

    assign TX_DATA_O = tx_q;
    assign OE_DATA_O = oe_q;

    always_comb begin
        cur_sel = '0;
        oor_sel = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_q == LANE_W'(i)) begin
                cur_sel = cur_tap_q[i];
                oor_sel = DELAY_LINE_OUT_OF_RANGE_I[i];
            end
        end
    end

    assign req_bad = (int'(lane_q) >= NUM_LANES) || (int'(val_q) > MAX_TAP);

    // After a LOAD the settle only confirms tap 0; no step is counted
    assign new_tap = from_load_q ? cur_sel :
                     dir_q       ? cur_sel + TAP_W'(1) : cur_sel - TAP_W'(1);

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            state_q     <= S_IDLE;
            lane_q      <= '0;
            val_q       <= '0;
            load_q      <= 1'b0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            from_load_q <= 1'b0;
            cnt_q       <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                cur_tap_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            val_q       <= val_d;
            load_q      <= load_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
            from_load_q <= from_load_d;
            cnt_q       <= cnt_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                cur_tap_q[i] <= cur_tap_d[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        val_d       = val_q;
        load_d      = load_q;
        dir_d       = dir_q;
        err_d       = err_q;
        from_load_d = from_load_q;
        cnt_d       = cnt_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            cur_tap_d[i] = cur_tap_q[i];
        end
        case (state_q)
            S_IDLE: begin
                if (TAP_REQ_VALID) begin
                    lane_d  = TAP_REQ_LANE;
                    val_d   = TAP_REQ_VAL;
                    load_d  = TAP_REQ_LOAD;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (req_bad) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (load_q) begin
                    state_d = S_LOAD;
                end else if (val_q == cur_sel) begin
                    state_d = S_DONE;
                end else begin
                    dir_d   = (val_q > cur_sel);
                    state_d = S_STEP;
                end
            end
            S_LOAD: begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (lane_q == LANE_W'(i)) cur_tap_d[i] = '0;
                end
                from_load_d = 1'b1;
                dir_d       = 1'b1;
                cnt_d       = '0;
                state_d     = S_SETTLE;
            end
            S_STEP: begin
                from_load_d = 1'b0;
                cnt_d       = '0;
                state_d     = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == 4'(SETTLE_CYC - 1)) begin
                    if (oor_sel) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        for (int i = 0; i < NUM_LANES; i++) begin
                            if (lane_q == LANE_W'(i)) cur_tap_d[i] = new_tap;
                        end
                        state_d = (new_tap == val_q) ? S_DONE : S_STEP;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pulses decode straight from state so an async reset drops them at once
    always_comb begin
        TAP_REQ_READY          = (state_q == S_IDLE);
        TAP_DONE               = (state_q == S_DONE);
        TAP_ERR                = (state_q == S_DONE) && err_q;
        DELAY_LINE_MOVE_O      = '0;
        DELAY_LINE_LOAD_O      = '0;
        DELAY_LINE_DIRECTION_O = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_q == LANE_W'(i)) begin
                DELAY_LINE_MOVE_O[i]      = (state_q == S_STEP);
                DELAY_LINE_LOAD_O[i]      = (state_q == S_LOAD);
                DELAY_LINE_DIRECTION_O[i] = dir_q &&
                    ((state_q == S_STEP) || (state_q == S_SETTLE && !from_load_q));
            end
        end
    end

`ifdef DDR3_CTRL_TAP_READBACK_EN
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_readback
        assign CUR_TAP_O[TAP_W*g +: TAP_W] = cur_tap_q[g];
    end
`endif

endmodule

// File: tb/tb_ddr3_ctrl_out_lane_pf.sv
// tb/tb_ddr3_ctrl_out_lane_pf.sv - scoreboard bench for ddr3_ctrl_out_lane_pf
module tb_ddr3_ctrl_out_lane_pf;

    logic       FAB_CLK = 1'b0;
    logic       ARST;
    logic [7:0] CMD_DATA;
    logic [1:0] CMD_OE_EN;
    logic [7:0] TX_DATA_O, OE_DATA_O;
    logic       TAP_REQ_VALID, TAP_REQ_READY;
    logic [1:0] TAP_REQ_LANE;
    logic [7:0] TAP_REQ_VAL;
    logic       TAP_REQ_LOAD, TAP_DONE, TAP_ERR;
    logic [1:0] MOVE, DIR, LOAD, OOR;
`ifdef DDR3_CTRL_TAP_READBACK_EN
    logic [15:0] CUR_TAP_O;
`endif

    ddr3_ctrl_out_lane_pf #(
        .NUM_LANES(2), .LANE_W(2), .TAP_W(8), .MAX_TAP(127), .SETTLE_CYC(3)
    ) dut (
        .FAB_CLK(FAB_CLK), .ARST(ARST),
        .CMD_DATA(CMD_DATA), .CMD_OE_EN(CMD_OE_EN),
        .TX_DATA_O(TX_DATA_O), .OE_DATA_O(OE_DATA_O),
        .TAP_REQ_VALID(TAP_REQ_VALID), .TAP_REQ_READY(TAP_REQ_READY),
        .TAP_REQ_LANE(TAP_REQ_LANE), .TAP_REQ_VAL(TAP_REQ_VAL),
        .TAP_REQ_LOAD(TAP_REQ_LOAD), .TAP_DONE(TAP_DONE), .TAP_ERR(TAP_ERR),
        .DELAY_LINE_MOVE_O(MOVE), .DELAY_LINE_DIRECTION_O(DIR),
        .DELAY_LINE_LOAD_O(LOAD), .DELAY_LINE_OUT_OF_RANGE_I(OOR)
`ifdef DDR3_CTRL_TAP_READBACK_EN
        , .CUR_TAP_O(CUR_TAP_O)
`endif
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int cyc = 0;
    always @(posedge FAB_CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // kind: 0 = LOAD pulse, 1 = MOVE pulse, 2 = DONE; arg = direction or err
    typedef struct {
        int cyc;
        int kind;
        int lane;
        int arg;
    } ev_t;

    ev_t q[$];
    int  mdl [2] = '{0, 0};

    task automatic push(input int c, input int kind, input int lane, input int arg);
        ev_t e;
        e.cyc = c; e.kind = kind; e.lane = lane; e.arg = arg;
        q.push_back(e);
    endtask

    // k = cycle in which the DUT sits in CHECK; oor_step = index of the step that sees out-of-range
    task automatic push_exp(input int k, input int lane, input int val, input int load, input int oor_step);
        int t, cur, dir, n;
        if (lane >= 2 || val > 127) begin
            push(k + 1, 2, lane, 1);
            return;
        end
        t = k + 1;
        cur = mdl[lane];
        if (load != 0) begin
            push(t, 0, lane, 0);
            t += 4;
            cur = 0;
        end
        if (val == cur) begin
            push(t, 2, lane, 0);
            mdl[lane] = cur;
            return;
        end
        dir = (val > cur) ? 1 : 0;
        n = dir ? val - cur : cur - val;
        for (int j = 0; j < n; j++) begin
            push(t, 1, lane, dir);
            if (j == oor_step) begin
                push(t + 4, 2, lane, 1);
                mdl[lane] = cur;
                return;
            end
            cur = dir ? cur + 1 : cur - 1;
            t += 4;
        end
        push(t, 2, lane, 0);
        mdl[lane] = val;
    endtask

    always @(negedge FAB_CLK) begin
        if (!ARST && ((|MOVE) || (|LOAD) || TAP_DONE)) begin
            if (q.size() == 0) begin
                check("unexpected_event", {29'd0, TAP_DONE, |LOAD, |MOVE}, 32'd0);
            end else begin
                ev_t e;
                e = q.pop_front();
                check("event_cycle", cyc, e.cyc);
                case (e.kind)
                    0: begin
                        check("load_vec", LOAD, 32'd1 << e.lane);
                        check("move_vec_at_load", MOVE, 32'd0);
                    end
                    1: begin
                        check("move_vec", MOVE, 32'd1 << e.lane);
                        check("dir_vec", DIR, e.arg << e.lane);
                        check("load_vec_at_move", LOAD, 32'd0);
                    end
                    default: begin
                        check("done_err", TAP_ERR, e.arg);
                        check("pulses_at_done", {MOVE, LOAD}, 32'd0);
                    end
                endcase
            end
        end
    end

    task automatic start_req(input int lane, input int val, input int load, input int oor_step, output int k);
        int n;
        n = 0;
        @(negedge FAB_CLK);
        while (!TAP_REQ_READY && n < 100) begin
            @(negedge FAB_CLK);
            n++;
        end
        check("ready_wait", TAP_REQ_READY, 1);
        TAP_REQ_VALID = 1'b1;
        TAP_REQ_LANE  = 2'(lane);
        TAP_REQ_VAL   = 8'(val);
        TAP_REQ_LOAD  = (load != 0);
        k = cyc + 1;
        push_exp(k, lane, val, load, oor_step);
        @(posedge FAB_CLK);
        #1;
        TAP_REQ_VALID = 1'b0;
        TAP_REQ_LANE  = 2'($urandom);
        TAP_REQ_VAL   = 8'($urandom);
        TAP_REQ_LOAD  = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge FAB_CLK);
            n++;
        end
        check("done_wait", q.size(), 0);
`ifdef DDR3_CTRL_TAP_READBACK_EN
        @(negedge FAB_CLK);
        check("readback_l0", CUR_TAP_O[7:0], mdl[0]);
        check("readback_l1", CUR_TAP_O[15:8], mdl[1]);
`endif
    endtask

    initial begin
        int k;
        logic [7:0] r;
        logic [1:0] oe;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        logic [7:0] r;
        logic [1:0] oe;
        ARST = 1'b1;
        CMD_DATA = 8'hA5;
        CMD_OE_EN = 2'b11;
        TAP_REQ_VALID = 1'b0;
        TAP_REQ_LANE = '0;
        TAP_REQ_VAL = '0;
        TAP_REQ_LOAD = 1'b0;
        OOR = '0;
        repeat (3) @(negedge FAB_CLK);
        check("rst_tx", TX_DATA_O, 0);
        check("rst_oe", OE_DATA_O, 0);
        check("rst_ready", TAP_REQ_READY, 1);
        check("rst_done_err", {TAP_DONE, TAP_ERR}, 0);
        check("rst_pulses", {MOVE, DIR, LOAD}, 0);
        ARST = 1'b0;
        @(negedge FAB_CLK);
        check("tx_after_rst", TX_DATA_O, 8'hA5);
        check("oe_after_rst", OE_DATA_O, 8'hFF);

        // LOAD then five steps up on lane 1
        start_req(1, 5, 1, -1, k);
        wait_idle();

        // Three steps down, data path exercised while the sequencer runs
        start_req(1, 2, 0, -1, k);
        for (int i = 0; i < 6; i++) begin
            @(negedge FAB_CLK);
            r = 8'($urandom);
            oe = 2'($urandom);
            CMD_DATA = r;
            CMD_OE_EN = oe;
            @(negedge FAB_CLK);
            check("tx_data", TX_DATA_O, r);
            check("oe_data", OE_DATA_O, {{4{oe[1]}}, {4{oe[0]}}});
        end
        wait_idle();

        // Illegal tap, illegal lane, load to zero
        start_req(1, 200, 0, -1, k);
        wait_idle();
        start_req(3, 5, 0, -1, k);
        wait_idle();
        start_req(0, 0, 1, -1, k);
        wait_idle();

        // Out-of-range reported during the 4th settle of lane 0
        start_req(0, 10, 0, 3, k);
        while (cyc < k + 13) @(negedge FAB_CLK);
        OOR = 2'b01;
        wait_idle();
        OOR = 2'b00;
        start_req(0, 3, 0, -1, k);
        wait_idle();

        // Highest legal tap on lane 1
        start_req(1, 127, 0, -1, k);
        wait_idle();

        // Reset during the third MOVE pulse of a 6-tap move
        start_req(0, 9, 0, -1, k);
        while (cyc < k + 8) @(negedge FAB_CLK);
        @(posedge FAB_CLK);
        #1;
        check("move_before_arst", MOVE, 2'b01);
        ARST = 1'b1;
        #1;
        check("move_in_arst", MOVE, 0);
        check("dir_in_arst", DIR, 0);
        check("ready_in_arst", TAP_REQ_READY, 1);
        q.delete();
        mdl[0] = 0;
        mdl[1] = 0;
        repeat (2) @(negedge FAB_CLK);
        check("tx_in_arst", TX_DATA_O, 0);
        ARST = 1'b0;
        start_req(0, 2, 0, -1, k);
        wait_idle();
        start_req(1, 1, 0, -1, k);
        wait_idle();

        check("sb_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
